// File: rtl/jogo_pkg.sv
// Shared types for the memory-game block: state codes, debug widths,
// default sequence ROM image and a counter-width helper.
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        NOVA_RODADA = 4'h2,
        ESPERA      = 4'h3,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROX_JOGADA = 4'h6,
        PROX_RODADA = 4'h7,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    localparam int DB_ESTADO_W = 4;

    // Entry 0 in the low nibble: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4
    localparam logic [63:0] ROM_DEFAULT = 64'h4188_4422_1124_8421;

    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/jogo_sequencia_param_if.sv
// Player-side and debug signals of the memory game; the board top drives
// iniciar/modo/chaves (master) and the game block answers (slave).
interface jogo_sequencia_param_if
    import jogo_pkg::*;
#(
    parameter int N = 4,
    parameter int A = 4
);
    logic                   iniciar;
    logic                   modo;
    logic [N-1:0]           chaves;
    logic                   pronto;
    logic                   acertou;
    logic                   errou;
    logic                   timeout;
    logic                   db_igual;
    logic [N-1:0]           db_jogada;
    logic [N-1:0]           db_memoria;
    logic [A-1:0]           db_endereco;
    logic [A-1:0]           db_rodada;
    logic [DB_ESTADO_W-1:0] db_estado;

    modport master (
        output iniciar, modo, chaves,
        input  pronto, acertou, errou, timeout, db_igual, db_jogada,
               db_memoria, db_endereco, db_rodada, db_estado
    );

    modport slave (
        input  iniciar, modo, chaves,
        output pronto, acertou, errou, timeout, db_igual, db_jogada,
               db_memoria, db_endereco, db_rodada, db_estado
    );
endinterface

// File: rtl/jogo_sequencia_param_contador_m.sv
// Saturating up-counter modulo M with synchronous clear/enable; fim flags
// the terminal value M-1 and the count holds there instead of wrapping.
module contador_m
    import jogo_pkg::*;
#(
    parameter  int M = 16,
    localparam int W = cnt_w(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         fim
);
    localparam logic [W-1:0] MAX = W'(M - 1);

    always_ff @(posedge clock) begin
        if (reset || clr)
            q <= '0;
        else if (en && (q != MAX))
            q <= q + 1'b1;
    end

    assign fim = (q == MAX);
endmodule

// File: rtl/jogo_sequencia_param.sv
// Parametrised memory-game datapath + control. Optional per-play timeout is
// enabled by defining TIMEOUT_EN (adds TIMEOUT_C parameter and timer).
module jogo_sequencia_param
    import jogo_pkg::*;
#(
    parameter int                 N        = 4,
    parameter int                 DEPTH    = 16,
    // Sequence ROM image, entry i at bits [i*N +: N]
    parameter logic [DEPTH*N-1:0] ROM_INIT = (DEPTH*N)'(ROM_DEFAULT)
`ifdef TIMEOUT_EN
    , parameter int               TIMEOUT_C = 5000
`endif
) (
    input logic                    clock,
    input logic                    reset,
    jogo_sequencia_param_if.slave  bus
);
    localparam int A = cnt_w(DEPTH);

    estado_t      estado, prox;
    logic [N-1:0] chaves_ant, jogada, memoria_q, rom_dado;
    logic [A-1:0] endereco, rodada;
    logic         igual_q, modo_q, borda, estourou;
    logic         fim_end, fim_rod, ultima_pos, ultima_rod;
    logic         pronto_q, acertou_q, errou_q, timeout_q;

    contador_m #(.M(DEPTH)) u_endereco (
        .clock (clock),
        .reset (reset),
        .clr   ((estado == PREPARA) || (estado == NOVA_RODADA)),
        .en    (estado == PROX_JOGADA),
        .q     (endereco),
        .fim   (fim_end)
    );

    contador_m #(.M(DEPTH)) u_rodada (
        .clock (clock),
        .reset (reset),
        .clr   (estado == PREPARA),
        .en    (estado == PROX_RODADA),
        .q     (rodada),
        .fim   (fim_rod)
    );

`ifdef TIMEOUT_EN
    logic [cnt_w(TIMEOUT_C)-1:0] timer;
    logic                        fim_timer;

    // Held at zero outside ESPERA, so every ESPERA visit starts a fresh window
    contador_m #(.M(TIMEOUT_C)) u_timer (
        .clock (clock),
        .reset (reset),
        .clr   (estado != ESPERA),
        .en    (estado == ESPERA),
        .q     (timer),
        .fim   (fim_timer)
    );
    assign estourou = fim_timer;
`else
    assign estourou = 1'b0;
`endif

    assign rom_dado   = ROM_INIT[int'(endereco)*N +: N];
    assign borda      = (|bus.chaves) && (chaves_ant == '0);
    assign ultima_pos = modo_q ? (endereco == rodada) : fim_end;
    assign ultima_rod = !modo_q || fim_rod;

    always_comb begin
        prox = estado;
        unique case (estado)
            INICIAL, FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                if (bus.iniciar) prox = PREPARA;
            PREPARA:     prox = NOVA_RODADA;
            NOVA_RODADA: prox = ESPERA;
            // A play arriving on the expiry cycle still counts
            ESPERA:
                if (borda)         prox = REGISTRA;
                else if (estourou) prox = FIM_TIMEOUT;
            REGISTRA:    prox = COMPARA;
            COMPARA:
                if (!igual_q)        prox = FIM_ERROU;
                else if (ultima_pos) prox = ultima_rod ? FIM_ACERTOU : PROX_RODADA;
                else                 prox = PROX_JOGADA;
            PROX_JOGADA: prox = ESPERA;
            PROX_RODADA: prox = NOVA_RODADA;
            default:     prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= INICIAL;
            chaves_ant <= '0;
            jogada     <= '0;
            memoria_q  <= '0;
            igual_q    <= 1'b0;
            modo_q     <= 1'b0;
            pronto_q   <= 1'b0;
            acertou_q  <= 1'b0;
            errou_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            estado     <= prox;
            chaves_ant <= bus.chaves;
            memoria_q  <= rom_dado;
            if (estado == PREPARA) begin
                modo_q  <= bus.modo;
                jogada  <= '0;
                igual_q <= 1'b0;
            end
            if ((estado == ESPERA) && borda)
                jogada <= bus.chaves;
            if (estado == REGISTRA)
                igual_q <= (jogada == rom_dado);
            // Flags decoded from the next state so they line up with db_estado
            pronto_q  <= prox inside {FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT};
            acertou_q <= (prox == FIM_ACERTOU);
            errou_q   <= prox inside {FIM_ERROU, FIM_TIMEOUT};
            timeout_q <= (prox == FIM_TIMEOUT);
        end
    end

    assign bus.pronto      = pronto_q;
    assign bus.acertou     = acertou_q;
    assign bus.errou       = errou_q;
    assign bus.timeout     = timeout_q;
    assign bus.db_igual    = igual_q;
    assign bus.db_jogada   = jogada;
    assign bus.db_memoria  = memoria_q;
    assign bus.db_endereco = endereco;
    assign bus.db_rodada   = rodada;
    assign bus.db_estado   = estado;
endmodule
